// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
// FSM state encoding and counter sizing helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder used as the per-bit stage
// of the serial adder.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic c_o
);

  assign sum_o = a_i ^ b_i ^ c_i;
  assign c_o   = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per cycle.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q;
  logic [WIDTH-2:0] sum_sr_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             accept, last;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] b_load, res_w;
  logic             seed;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = b ^ {WIDTH{sub}};
  assign seed   = c_in ^ sub;
`else
  assign b_load = b;
  assign seed   = c_in;
`endif

  assign accept = (state_q == IDLE) && in_valid;
  assign last   = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

  full_adder u_fa (
    .a_i   (a_sr_q[0]),
    .b_i   (b_sr_q[0]),
    .c_i   (carry_q),
    .sum_o (fa_s),
    .c_o   (fa_co)
  );

  // sum_sr holds the low WIDTH-1 bits; the top bit comes straight from the adder
  assign res_w = {fa_s, sum_sr_q};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else if (accept) begin
      a_sr_q   <= a;
      b_sr_q   <= b_load;
      carry_q  <= seed;
      cnt_q    <= '0;
    end else if (state_q == RUN) begin
      a_sr_q   <= a_sr_q >> 1;
      b_sr_q   <= b_sr_q >> 1;
      sum_sr_q <= res_w[WIDTH-1:1];
      carry_q  <= fa_co;
      cnt_q    <= cnt_q + CW'(1);
      if (last) begin
        sum_q  <= res_w;
        cout_q <= fa_co;
      end
    end
  end

  assign sum   = sum_q;
  assign c_out = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8).
// Reference model is plain integer arithmetic.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       c_in = 1'b0;
  logic       sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] sum;
  logic       c_out;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic c, input logic s);
    int r;
    if (s) r = 256 + int'(x) - int'(y) - int'(c);
    else   r = int'(x) + int'(y) + int'(c);
    return r[8:0];
  endfunction

  // Issue one operation, wait for the result, release it after `stall` cycles.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv,
                        input logic tc, input logic ts, input int stall,
                        output logic [7:0] rs, output logic rc,
                        output int lat, output bit tmo);
    int w;
    tmo = 1'b0;
    in_valid = 1'b1; a = ta; b = tbv; c_in = tc; sub = ts;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) tmo = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) tmo = 1'b1;
    rs = sum; rc = c_out;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy, sum, c_out} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state got rdy=%b ov=%b busy=%b sum=%h co=%b exp 1 0 0 00 0",
               in_ready, out_valid, busy, sum, c_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_op(input string nm, input logic [7:0] ta, input logic [7:0] tbv,
                          input logic tc, input logic ts, input int stall);
    logic [7:0] rs; logic rc; int lat; bit tmo; logic [8:0] exp;
    exp = model(ta, tbv, tc, ts);
    run_op(ta, tbv, tc, ts, stall, rs, rc, lat, tmo);
    n_cmp++;
    if (tmo || lat != 8) begin
      n_bad++;
      $display("FAIL %s_latency got=%0d tmo=%0d exp=8", nm, lat, tmo);
    end
    n_cmp++;
    if ({rc, rs} !== exp) begin
      n_bad++;
      $display("FAIL %s_result a=%h b=%h c=%b s=%b got=%h exp=%h",
               nm, ta, tbv, tc, ts, {rc, rs}, exp);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    check_op("basic", 8'h5A, 8'h3C, 1'b0, 1'b0, 0);
    n_cmp++;
    if ({c_out, sum} !== 9'h096) begin
      n_bad++;
      $display("FAIL basic_const got=%h exp=096", {c_out, sum});
    end
  endtask

  task automatic test_ripple();
    check_op("ripple1", 8'hFF, 8'h01, 1'b0, 1'b0, 0);
    n_cmp++;
    if ({c_out, sum} !== 9'h100) begin
      n_bad++;
      $display("FAIL ripple1_const got=%h exp=100", {c_out, sum});
    end
    check_op("ripple2", 8'hFF, 8'hFF, 1'b1, 1'b0, 1);
    n_cmp++;
    if ({c_out, sum} !== 9'h1FF) begin
      n_bad++;
      $display("FAIL ripple2_const got=%h exp=1ff", {c_out, sum});
    end
  endtask

  task automatic test_stall();
    logic [7:0] s0; int w; bit ok;
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'h12; b = 8'h34; c_in = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    a = 8'h77; b = 8'h11; c_in = 1'b1;
    w = 0;
    while (!out_valid && w < 50) begin
      @(posedge clk); #1; w++;
    end
    s0 = sum;
    n_cmp++;
    if (!out_valid || {c_out, sum} !== 9'h046) begin
      n_bad++;
      $display("FAIL stall_first got ov=%b val=%h exp ov=1 val=046", out_valid, {c_out, sum});
    end
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!out_valid || sum !== s0 || in_ready) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL stall_hold got ov=%b sum=%h rdy=%b exp ov=1 sum=%h rdy=0",
               out_valid, sum, in_ready, s0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid || !in_ready || sum !== s0) begin
      n_bad++;
      $display("FAIL stall_release got ov=%b rdy=%b sum=%h exp ov=0 rdy=1 sum=%h",
               out_valid, in_ready, sum, s0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (!busy || in_ready) begin
      n_bad++;
      $display("FAIL stall_accept got busy=%b rdy=%b exp busy=1 rdy=0", busy, in_ready);
    end
    w = 0;
    while (!out_valid && w < 50) begin
      @(posedge clk); #1; w++;
    end
    n_cmp++;
    if (!out_valid || {c_out, sum} !== model(8'h77, 8'h11, 1'b1, 1'b0)) begin
      n_bad++;
      $display("FAIL stall_second got ov=%b val=%h exp=%h", out_valid, {c_out, sum},
               model(8'h77, 8'h11, 1'b1, 1'b0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    in_valid = 1'b1; a = 8'hAB; b = 8'hCD; c_in = 1'b1; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready, out_valid, busy, sum, c_out} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL midrun_reset got rdy=%b ov=%b busy=%b sum=%h co=%b exp 1 0 0 00 0",
               in_ready, out_valid, busy, sum, c_out);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    check_op("after_reset", 8'h01, 8'h02, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa [3]; logic [7:0] ob [3]; logic oc [3];
    int acc [3]; logic [8:0] res [3];
    int n, m, i; bit fire, ov; logic [8:0] rv;
    for (int k = 0; k < 3; k++) begin
      oa[k] = 8'($urandom); ob[k] = 8'($urandom); oc[k] = 1'($urandom);
    end
    n = 0; m = 0; i = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; a = oa[0]; b = ob[0]; c_in = oc[0]; sub = 1'b0;
    while (m < 3 && i < 200) begin
      fire = in_ready && in_valid;
      ov = out_valid;
      rv = {c_out, sum};
      @(posedge clk);
      i++;
      if (fire) begin acc[n] = i; n++; end
      if (ov) begin res[m] = rv; m++; end
      #1;
      if (n < 3) begin a = oa[n]; b = ob[n]; c_in = oc[n]; end
      else in_valid = 1'b0;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (m != 3 || n != 3) begin
      n_bad++;
      $display("FAIL b2b_count got acc=%0d res=%0d exp 3 3", n, m);
    end else begin
      for (int k = 1; k < 3; k++) begin
        n_cmp++;
        if (acc[k] - acc[k-1] != 10) begin
          n_bad++;
          $display("FAIL b2b_interval%0d got=%0d exp=10", k, acc[k] - acc[k-1]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (res[k] !== model(oa[k], ob[k], oc[k], 1'b0)) begin
          n_bad++;
          $display("FAIL b2b_result%0d got=%h exp=%h", k, res[k],
                   model(oa[k], ob[k], oc[k], 1'b0));
        end
      end
    end
  endtask

  task automatic test_random();
    logic ts;
    for (int k = 0; k < 16; k++) begin
`ifdef SERIAL_ADDER_SUB_EN
      ts = 1'($urandom);
`else
      ts = 1'b0;
`endif
      check_op("random", 8'($urandom), 8'($urandom), 1'($urandom), ts,
               int'($urandom_range(0, 3)));
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    check_op("sub1", 8'h10, 8'h01, 1'b0, 1'b1, 0);
    n_cmp++;
    if ({c_out, sum} !== 9'h10F) begin
      n_bad++;
      $display("FAIL sub1_const got=%h exp=10f", {c_out, sum});
    end
    check_op("sub2", 8'h01, 8'h10, 1'b0, 1'b1, 0);
    n_cmp++;
    if ({c_out, sum} !== 9'h0F1) begin
      n_bad++;
      $display("FAIL sub2_const got=%h exp=0f1", {c_out, sum});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_stall();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
